// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : irq_pkg
// Description : Shared definitions for the interrupt controller / responder
//               pair: source count, id width, responder state encoding and
//               the handler vector address helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package irq_pkg;

  localparam int NUM_IRQ = 4;
  localparam int ID_W    = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ACK      = 3'd1,
    DISPATCH = 3'd2,
    SERVICE  = 3'd3,
    EOI      = 3'd4
  } irq_state_e;

  // Full-width vector address; the caller truncates to its own vector width.
  function automatic logic [31:0] vec_addr(input logic [31:0]     base,
                                           input logic [31:0]     stride,
                                           input logic [ID_W-1:0] id);
    return base + (32'(id) * stride);
  endfunction

endpackage
`default_nettype wire

// File: rtl/interrupt_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_responder_if
// Description : Bundle of controller handshake, core handshake and status
//               signals between the interrupt responder and its environment.
// Modports    : master - responder side (drives ack/start/vec/eoi/status)
//               slave  - environment side (controller, core, software)
// Revision    : 1.0 - initial release
// ============================================================================
interface interrupt_responder_if #(
  parameter int VEC_W = 16,
  parameter int CNT_W = 8
);
  import irq_pkg::*;

  // controller side
  logic              int_req;
  logic [ID_W-1:0]   int_id;
  logic              int_ack;
  // enables
  logic              int_en;
  logic [NUM_IRQ-1:0] int_mask;
  // core side
  logic              isr_start;
  logic [VEC_W-1:0]  isr_vec;
  logic [ID_W-1:0]   active_id;
  logic              busy;
  logic              isr_done;
  logic              eoi;
  // status
  logic              timeout_err;
  logic              clr_err;
  logic [ID_W-1:0]   cnt_sel;
  logic [CNT_W-1:0]  cnt_out;

  modport master (
    input  int_req, int_id, int_en, int_mask, isr_done, clr_err, cnt_sel,
    output int_ack, isr_start, isr_vec, active_id, busy, eoi, timeout_err,
           cnt_out
  );

  modport slave (
    output int_req, int_id, int_en, int_mask, isr_done, clr_err, cnt_sel,
    input  int_ack, isr_start, isr_vec, active_id, busy, eoi, timeout_err,
           cnt_out
  );

endinterface
`default_nettype wire

// File: rtl/irq_svc_counters.sv
`default_nettype none
// ============================================================================
// Module      : irq_svc_counters
// Description : One saturating service counter per interrupt source, with a
//               single increment port and a combinational read port.
// Ports       : clk     - rising-edge clock
//               rst     - synchronous active-low reset
//               inc     - increment the counter addressed by inc_id
//               inc_id  - source id to increment
//               sel     - source id to read
//               cnt_out - value of counter sel
// Revision    : 1.0 - initial release
// ============================================================================
module irq_svc_counters
  import irq_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic [ID_W-1:0]   inc_id,
  input  logic [ID_W-1:0]   sel,
  output logic [CNT_W-1:0]  cnt_out
);

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  logic [CNT_W-1:0] w_cnt [NUM_IRQ];

  for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_cnt
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
      if (!rst) begin
        r_cnt <= '0;
      end else if (inc && (inc_id == ID_W'(gi)) && (r_cnt != c_cnt_max)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end

    assign w_cnt[gi] = r_cnt;
  end

  assign cnt_out = w_cnt[sel];

endmodule
`default_nettype wire

// File: rtl/interrupt_responder.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_responder
// Description : CPU-side partner of the priority interrupt controller.
//               Captures the presented id, acknowledges it for one cycle,
//               launches the handler at its vector, waits for completion or
//               timeout, pulses end-of-interrupt and counts services per id.
// Ports       : clk  - rising-edge clock
//               rst  - synchronous active-low reset
//               bus  - interrupt_responder_if.master:
//                      int_req/int_id/int_ack   controller handshake
//                      int_en/int_mask          global enable, per-id mask
//                      isr_start/isr_vec        handler launch and address
//                      active_id/busy           service status
//                      isr_done/eoi             completion and end pulse
//                      timeout_err/clr_err      sticky abort flag and clear
//                      cnt_sel/cnt_out          service counter read
// Revision    : 1.0 - initial release
// ============================================================================
module interrupt_responder
  import irq_pkg::*;
#(
  parameter int               VEC_W      = 16,
  parameter logic [VEC_W-1:0] VEC_BASE   = 16'h0100,
  parameter logic [VEC_W-1:0] VEC_STRIDE = 16'h0010,
  parameter int               TIMEOUT    = 255,
  parameter int               TO_W       = 8,
  parameter int               CNT_W      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  interrupt_responder_if.master  bus
);

  // Counter value on the last permitted SERVICE cycle.
  localparam logic [TO_W-1:0] c_to_last = TO_W'(TIMEOUT - 1);

  irq_state_e       r_state;
  irq_state_e       w_state_next;

  logic             w_cap;
  logic             w_to_inc;
  logic             w_to_set;
  logic             w_cnt_inc;

  logic [TO_W-1:0]  r_to_cnt;
  logic             r_ack;
  logic             r_start;
  logic             r_eoi;
  logic             r_busy;
  logic             r_err;
  logic [ID_W-1:0]  r_active;
  logic [VEC_W-1:0] r_vec;
  logic [VEC_W-1:0] w_vec;

  assign w_vec = VEC_W'(vec_addr(32'(VEC_BASE), 32'(VEC_STRIDE), r_active));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_cap        = 1'b0;
    w_to_inc     = 1'b0;
    w_to_set     = 1'b0;

    case (r_state)
      IDLE: begin
        // A masked top-priority id simply stalls here: the controller never
        // shows a lower-priority id while a higher one is pending.
        if (bus.int_en && bus.int_req && !bus.int_mask[bus.int_id]) begin
          w_cap        = 1'b1;
          w_state_next = ACK;
        end
      end
      ACK:      w_state_next = DISPATCH;
      DISPATCH: w_state_next = SERVICE;
      SERVICE: begin
        // Completion takes precedence over expiry on the same cycle.
        if (bus.isr_done) begin
          w_state_next = EOI;
        end else if (r_to_cnt == c_to_last) begin
          w_to_set     = 1'b1;
          w_state_next = EOI;
        end else begin
          w_to_inc     = 1'b1;
        end
      end
      EOI:      w_state_next = IDLE;
      default:  w_state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Registered outputs and datapath. Pulses are decoded from the next state
  // so that each one is high exactly while the FSM sits in its state.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ack    <= 1'b0;
      r_start  <= 1'b0;
      r_eoi    <= 1'b0;
      r_busy   <= 1'b0;
      r_active <= '0;
      r_vec    <= '0;
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      r_ack   <= (w_state_next == ACK);
      r_start <= (w_state_next == DISPATCH);
      r_eoi   <= (w_state_next == EOI);
      r_busy  <= (w_state_next != IDLE);

      if (w_cap) begin
        r_active <= bus.int_id;
      end

      // r_active settled one edge earlier, so the vector is ready for the
      // isr_start cycle.
      if (w_state_next == DISPATCH) begin
        r_vec <= w_vec;
      end

      if (r_state == DISPATCH) begin
        r_to_cnt <= '0;
      end else if (w_to_inc) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end

      // Setting the sticky error beats a simultaneous clear.
      if (w_to_set) begin
        r_err <= 1'b1;
      end else if (bus.clr_err) begin
        r_err <= 1'b0;
      end
    end
  end

  assign w_cnt_inc = (r_state == EOI);

  irq_svc_counters #(
    .CNT_W (CNT_W)
  ) u_counters (
    .clk     (clk),
    .rst     (rst),
    .inc     (w_cnt_inc),
    .inc_id  (r_active),
    .sel     (bus.cnt_sel),
    .cnt_out (bus.cnt_out)
  );

  assign bus.int_ack     = r_ack;
  assign bus.isr_start   = r_start;
  assign bus.isr_vec     = r_vec;
  assign bus.active_id   = r_active;
  assign bus.busy        = r_busy;
  assign bus.eoi         = r_eoi;
  assign bus.timeout_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_interrupt_responder
// Description : Scoreboard bench for interrupt_responder. dut_a uses default
//               parameters and can be driven by a small controller model;
//               dut_b uses TIMEOUT=4, CNT_W=2 for timeout and saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interrupt_responder;

  localparam logic [1:0] K_ACK   = 2'd0;
  localparam logic [1:0] K_START = 2'd1;
  localparam logic [1:0] K_EOI   = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t exp_a[$];
  exp_t exp_b[$];

  // ---------------- environment drives ----------------
  logic       a_en = 0, a_req = 0, a_done = 0, a_clr = 0;
  logic [1:0] a_id = 0, a_sel = 0;
  logic [3:0] a_mask = 0;
  logic       b_en = 0, b_req = 0, b_done = 0, b_clr = 0;
  logic [1:0] b_id = 0, b_sel = 0;
  logic [3:0] b_mask = 0;

  // controller model (higher id = higher priority)
  logic       ctrl_mode = 0;
  logic       ctrl_load = 1;
  logic [3:0] ctrl_val  = 0;
  logic [3:0] pending;

  function automatic logic [1:0] top_id(input logic [3:0] p);
    if (p[3]) return 2'd3;
    if (p[2]) return 2'd2;
    if (p[1]) return 2'd1;
    return 2'd0;
  endfunction

  interrupt_responder_if #(.VEC_W(16), .CNT_W(8)) bus_a ();
  interrupt_responder_if #(.VEC_W(16), .CNT_W(2)) bus_b ();

  assign bus_a.int_req  = ctrl_mode ? (|pending) : a_req;
  assign bus_a.int_id   = ctrl_mode ? top_id(pending) : a_id;
  assign bus_a.isr_done = ctrl_mode | a_done;
  assign bus_a.int_en   = a_en;
  assign bus_a.int_mask = a_mask;
  assign bus_a.clr_err  = a_clr;
  assign bus_a.cnt_sel  = a_sel;

  assign bus_b.int_req  = b_req;
  assign bus_b.int_id   = b_id;
  assign bus_b.isr_done = b_done;
  assign bus_b.int_en   = b_en;
  assign bus_b.int_mask = b_mask;
  assign bus_b.clr_err  = b_clr;
  assign bus_b.cnt_sel  = b_sel;

  always @(posedge clk) begin
    if (ctrl_load) pending <= ctrl_val;
    else if (ctrl_mode && bus_a.int_ack) pending[bus_a.int_id] <= 1'b0;
  end

  interrupt_responder dut_a (.clk(clk), .rst(rst), .bus(bus_a));

  interrupt_responder #(
    .VEC_W(16), .VEC_BASE(16'h0100), .VEC_STRIDE(16'h0010),
    .TIMEOUT(4), .TO_W(8), .CNT_W(2)
  ) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int d, input exp_t e);
    if (d == 0) exp_a.push_back(e);
    else        exp_b.push_back(e);
  endtask

  task automatic expect_svc(input int d, input logic [1:0] id, input logic [15:0] vec,
                            input logic err, input bit with_eoi);
    push(d, '{kind: K_ACK,   val: 16'(id)});
    push(d, '{kind: K_START, val: vec});
    if (with_eoi) push(d, '{kind: K_EOI, val: 16'({err, id})});
  endtask

  task automatic sb_pop(input int d, input logic [1:0] kind, input logic [15:0] val);
    exp_t e;
    bit   empty;
    empty = (d == 0) ? (exp_a.size() == 0) : (exp_b.size() == 0);
    n_checks++;
    if (empty) begin
      n_fail++;
      $display("FAIL sb_dut%0d: unexpected event kind %0d val %0h, required none", d, kind, val);
    end else begin
      if (d == 0) e = exp_a.pop_front();
      else        e = exp_b.pop_front();
      if (e.kind !== kind || e.val !== val) begin
        n_fail++;
        $display("FAIL sb_dut%0d: got kind %0d val %0h required kind %0d val %0h",
                 d, kind, val, e.kind, e.val);
      end
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      if (bus_a.int_ack)   sb_pop(0, K_ACK,   16'(bus_a.active_id));
      if (bus_a.isr_start) sb_pop(0, K_START, bus_a.isr_vec);
      if (bus_a.eoi)       sb_pop(0, K_EOI,   16'({bus_a.timeout_err, bus_a.active_id}));
      if (bus_b.int_ack)   sb_pop(1, K_ACK,   16'(bus_b.active_id));
      if (bus_b.isr_start) sb_pop(1, K_START, bus_b.isr_vec);
      if (bus_b.eoi)       sb_pop(1, K_EOI,   16'({bus_b.timeout_err, bus_b.active_id}));
    end
  end

  function automatic logic get_ack(input int d);
    return (d == 0) ? bus_a.int_ack : bus_b.int_ack;
  endfunction
  function automatic logic get_busy(input int d);
    return (d == 0) ? bus_a.busy : bus_b.busy;
  endfunction
  function automatic logic get_eoi(input int d);
    return (d == 0) ? bus_a.eoi : bus_b.eoi;
  endfunction

  task automatic wait_ack(input int d, input string name);
    int k = 0;
    while (!get_ack(d) && k < 10) begin
      cyc(1);
      k++;
    end
    chk(name, k, 1);
  endtask

  task automatic wait_idle(input int d, input string name);
    int k = 0;
    while (get_busy(d) && k < 600) begin
      cyc(1);
      k++;
    end
    chk(name, get_busy(d), 0);
  endtask

  task automatic wait_eoi(input int d, input string name);
    int k = 0;
    while (!get_eoi(d) && k < 20) begin
      cyc(1);
      k++;
    end
    chk(name, get_eoi(d), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int seen;
    int svc;

    cyc(2);
    ctrl_load = 0;
    chk("rst_ack",   bus_a.int_ack, 0);
    chk("rst_start", bus_a.isr_start, 0);
    chk("rst_busy",  bus_a.busy, 0);
    chk("rst_vec",   bus_a.isr_vec, 0);
    chk("rst_err_b", bus_b.timeout_err, 0);
    rst = 1;
    cyc(1);

    // ---- basic service on dut_a, id 2 ----
    a_en = 1;
    expect_svc(0, 2'd2, 16'h0120, 1'b0, 1);
    a_req = 1; a_id = 2'd2;
    wait_ack(0, "basic_ack_lat");
    a_req = 0;
    cyc(1);
    chk("basic_start", bus_a.isr_start, 1);
    chk("basic_vec",   bus_a.isr_vec, 16'h0120);
    chk("basic_ack_1cyc", bus_a.int_ack, 0);
    cyc(4);
    a_done = 1;
    cyc(1);
    chk("basic_eoi", bus_a.eoi, 1);
    a_done = 0;
    cyc(1);
    a_sel = 2'd2; #1;
    chk("basic_cnt2", bus_a.cnt_out, 1);
    chk("basic_idle", bus_a.busy, 0);

    // ---- back-to-back with controller model, pending 1001 ----
    expect_svc(0, 2'd3, 16'h0130, 1'b0, 1);
    expect_svc(0, 2'd0, 16'h0100, 1'b0, 1);
    ctrl_mode = 1; ctrl_val = 4'b1001; ctrl_load = 1;
    cyc(1);
    ctrl_load = 0;
    seen = 0;
    while ((pending != 0 || bus_a.busy) && seen < 40) begin
      cyc(1);
      seen++;
    end
    chk("b2b_pending", pending, 0);
    chk("b2b_idle", bus_a.busy, 0);
    ctrl_mode = 0;
    cyc(1);
    a_sel = 2'd3; #1;
    chk("b2b_cnt3", bus_a.cnt_out, 1);
    a_sel = 2'd0; #1;
    chk("b2b_cnt0", bus_a.cnt_out, 1);

    // ---- mask / enable on dut_a ----
    a_mask = 4'b0010; a_id = 2'd1; a_req = 1;
    seen = 0;
    repeat (20) begin
      cyc(1);
      if (bus_a.int_ack) seen++;
    end
    chk("mask_no_ack", seen, 0);
    expect_svc(0, 2'd1, 16'h0110, 1'b0, 1);
    a_mask = 4'b0000;
    wait_ack(0, "unmask_ack_lat");
    a_req = 0; a_done = 1;
    wait_idle(0, "unmask_done");
    a_done = 0;
    a_en = 0; a_req = 1;
    seen = 0;
    repeat (20) begin
      cyc(1);
      if (bus_a.int_ack) seen++;
    end
    chk("disable_no_ack", seen, 0);
    a_req = 0; a_en = 1;
    a_sel = 2'd1; #1;
    chk("mask_cnt1", bus_a.cnt_out, 1);

    // ---- timeout on dut_b ----
    b_en = 1;
    expect_svc(1, 2'd0, 16'h0100, 1'b1, 1);
    b_req = 1; b_id = 2'd0;
    wait_ack(1, "to_ack_lat");
    b_req = 0;
    cyc(1);
    chk("to_start", bus_b.isr_start, 1);
    svc = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(1);
      if (bus_b.eoi) break;
      svc++;
    end
    chk("to_svc_cycles", svc, 4);
    chk("to_err_set", bus_b.timeout_err, 1);
    b_clr = 1;
    cyc(1);
    chk("to_err_clr", bus_b.timeout_err, 0);
    b_clr = 0;

    // isr_done on the last permitted SERVICE cycle
    expect_svc(1, 2'd2, 16'h0120, 1'b0, 1);
    b_req = 1; b_id = 2'd2;
    wait_ack(1, "edge_ack_lat");
    b_req = 0;
    cyc(1);
    cyc(4);
    b_done = 1;
    cyc(1);
    chk("edge_eoi", bus_b.eoi, 1);
    chk("edge_no_err", bus_b.timeout_err, 0);
    b_done = 0;
    cyc(1);

    // timeout while clr_err held: set wins
    expect_svc(1, 2'd1, 16'h0110, 1'b1, 1);
    b_clr = 1; b_req = 1; b_id = 2'd1;
    wait_ack(1, "setwin_ack_lat");
    b_req = 0;
    wait_eoi(1, "setwin_eoi");
    chk("setwin_err", bus_b.timeout_err, 1);
    cyc(1);
    chk("setwin_clr", bus_b.timeout_err, 0);
    b_clr = 0;

    // ---- saturation: id 1 five more times, CNT_W=2 ----
    b_done = 1;
    for (int i = 0; i < 5; i++) begin
      expect_svc(1, 2'd1, 16'h0110, 1'b0, 1);
      b_req = 1; b_id = 2'd1;
      wait_ack(1, "sat_ack_lat");
      b_req = 0;
      wait_idle(1, "sat_idle");
    end
    b_done = 0;
    b_sel = 2'd1; #1;
    chk("sat_cnt1", bus_b.cnt_out, 3);
    b_sel = 2'd0; #1;
    chk("sat_cnt0", bus_b.cnt_out, 1);
    b_sel = 2'd2; #1;
    chk("sat_cnt2", bus_b.cnt_out, 1);

    // ---- reset mid-SERVICE on dut_a ----
    expect_svc(0, 2'd3, 16'h0130, 1'b0, 0);
    a_req = 1; a_id = 2'd3;
    wait_ack(0, "rstsvc_ack_lat");
    a_req = 0;
    cyc(3);
    chk("rstsvc_busy_pre", bus_a.busy, 1);
    rst = 0;
    cyc(2);
    chk("rstsvc_busy",   bus_a.busy, 0);
    chk("rstsvc_eoi",    bus_a.eoi, 0);
    chk("rstsvc_active", bus_a.active_id, 0);
    chk("rstsvc_vec",    bus_a.isr_vec, 0);
    chk("rstsvc_err",    bus_a.timeout_err, 0);
    for (int s = 0; s < 4; s++) begin
      a_sel = 2'(s); #1;
      chk("rstsvc_cnt_a", bus_a.cnt_out, 0);
    end
    b_sel = 2'd1; #1;
    chk("rstsvc_cnt_b", bus_b.cnt_out, 0);
    rst = 1;
    cyc(5);
    chk("rstsvc_stay_idle", bus_a.busy, 0);

    chk("sb_a_drained", exp_a.size(), 0);
    chk("sb_b_drained", exp_b.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
